// File: rtl/rv_multicycle_control.sv
// rv_multicycle_control: multi-cycle RV32I control FSM.
// Sequences fetch/decode/execute/memory/writeback against a handshaked
// shared memory, traps on illegal encodings and memory timeouts.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   opcode, funct3        instruction register fields
//   br_cond               ALU branch condition
//   mem_ready             memory completes the current request
//   mem_req, mem_we       memory request / write strobe
//   adr_src               0 = PC, 1 = ALUOut
//   ir_write, pc_write    IR/oldPC load, PC load
//   reg_write             register-file write
//   alu_src_a/b, alu_op   ALU operand and operation selects
//   result_src            result mux select
//   jalr_mask             clear bit 0 of the PC load value
//   instret               retire pulse
//   halted, cause         sticky trap indication and reason
module rv_multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       jalr_mask,
  output logic       instret,
  output logic       halted,
  output logic [1:0] cause
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TO  = 2'b10;

  // Counter value seen during the last allowed waiting cycle.
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_ALUWB,
    S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_JAL, S_JALR,
    S_JWB, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             timeout_c;

  // State, wait counter and trap cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign timeout_c = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LIMIT) && !mem_ready;

  // Next-state logic; the counter only survives while a request is stalled,
  // so it is zero on every entry into a requesting state.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = '0;
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          unique case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_MEMREAD: state_d = S_MEMWB;
            default:   state_d = S_FETCH;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout_c) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TO;
          end
        end
      end
      S_DECODE: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILL;
        unique case (opcode)
          OP_R:     begin state_d = S_EXECR; cause_d = cause_q; end
          OP_I:     begin state_d = S_EXECI; cause_d = cause_q; end
          OP_JAL:   begin state_d = S_JAL;   cause_d = cause_q; end
          OP_LUI:   begin state_d = S_LUI;   cause_d = cause_q; end
          OP_AUIPC: begin state_d = S_AUIPC; cause_d = cause_q; end
          OP_LOAD:
            if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
              state_d = S_MEMADR;
              cause_d = cause_q;
            end
          OP_STORE:
            if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
              state_d = S_MEMADR;
              cause_d = cause_q;
            end
          OP_BRANCH:
            if (!(funct3 inside {3'b010, 3'b011})) begin
              state_d = S_BRANCH;
              cause_d = cause_q;
            end
          OP_JALR:
            if (funct3 == 3'b000) begin
              state_d = S_JALR;
              cause_d = cause_q;
            end
          default: ;
        endcase
      end
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_d = S_ALUWB;
      // IR is held through the instruction, so opcode still selects direction.
      S_MEMADR: state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_JALR:   state_d = S_JWB;
      S_ALUWB, S_MEMWB, S_BRANCH, S_JAL, S_JWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RST;
    endcase
  end

  // Output decode of the current state.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    jalr_mask  = 1'b0;
    instret    = 1'b0;
    halted     = 1'b0;
    cause      = cause_q;
    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR, S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        instret   = 1'b1;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instret    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        instret = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = br_cond;
        instret   = 1'b1;
      end
      // PC loads ALUOut via result_src=00; rd gets PC on its own datapath path.
      S_JAL, S_JWB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        instret   = 1'b1;
        jalr_mask = (state_q == S_JWB);
      end
      S_TRAP: halted = 1'b1;
      default: cause = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_control.sv
// Scoreboard bench for rv_multicycle_control (MEM_TIMEOUT=4).
// Stimulus pushes the expected 19-bit output vector for each cycle;
// a negedge monitor pops and compares against the DUT outputs.
module tb_rv_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_cond;
  logic       mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, cause;
  logic       jalr_mask, instret, halted;

  always #5 clk = ~clk;

  rv_multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .br_cond(br_cond), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .jalr_mask(jalr_mask), .instret(instret), .halted(halted), .cause(cause)
  );

  // {req,we,adr,irw,pcw,rw} {a,b,op,rs} {jm,instret,halted} {cause}
  localparam logic [18:0] E_RST      = '0;
  localparam logic [18:0] E_FETCH    = {6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
  localparam logic [18:0] E_FETCH_R  = {6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
  localparam logic [18:0] E_DECODE   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_EXECR    = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_EXECI    = {6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_LUI      = {6'b000000, 2'b11, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_AUIPC    = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_MEMADR   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_MEMREAD  = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_MEMWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, 2'b00};
  localparam logic [18:0] E_MEMWR    = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_MEMWR_R  = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_BR0      = {6'b000000, 2'b10, 2'b00, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_BR1      = {6'b000010, 2'b10, 2'b00, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_JAL      = {6'b000011, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_JALR     = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] E_JWB      = {6'b000011, 2'b00, 2'b00, 2'b00, 2'b00, 3'b110, 2'b00};
  localparam logic [18:0] E_TRAP_ILL = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 2'b01};
  localparam logic [18:0] E_TRAP_TO  = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 2'b10};

  typedef struct {
    logic [18:0] e;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   step_id = 0;
  int   total = 0;
  int   bad = 0;

  logic [18:0] act;
  assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src,
                jalr_mask, instret, halted, cause};

  // Monitor: one expected vector per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t it;
      it = sb.pop_front();
      total = total + 1;
      if (act !== it.e) begin
        bad = bad + 1;
        $display("FAIL step%0d outputs got=%b want=%b", it.id, act, it.e);
      end
    end
  end

  // Immediate check of the current outputs.
  task automatic chk(input string name, input logic [18:0] e);
    total = total + 1;
    if (act !== e) begin
      bad = bad + 1;
      $display("FAIL %s got=%b want=%b", name, act, e);
    end
  endtask

  task automatic push_wait(input logic [18:0] e);
    exp_t it;
    it.e  = e;
    it.id = step_id;
    step_id = step_id + 1;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rdy, input logic br, input logic [18:0] e);
    mem_ready = rdy;
    br_cond   = br;
    push_wait(e);
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    push_wait(E_RST);
    chk("reset_state", E_RST);
    rst_n = 1'b1;
    push_wait(E_RST);
  endtask

  // Fetch + decode with zero wait states.
  task automatic fd();
    step(1'b1, 1'b0, E_FETCH_R);
    step(1'b1, 1'b0, E_DECODE);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 7'b0110011;
    funct3 = 3'b000;
    br_cond = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // add, addi, lui, auipc: 4 cycles each
    set_ir(7'b0110011, 3'b000); fd(); step(1, 0, E_EXECR); step(1, 0, E_ALUWB);
    set_ir(7'b0010011, 3'b000); fd(); step(1, 0, E_EXECI); step(1, 0, E_ALUWB);
    set_ir(7'b0110111, 3'b000); fd(); step(1, 0, E_LUI);   step(1, 0, E_ALUWB);
    set_ir(7'b0010111, 3'b000); fd(); step(1, 0, E_AUIPC); step(1, 0, E_ALUWB);

    // lw with three wait cycles in MEMREAD: 8 cycles
    set_ir(7'b0000011, 3'b010); fd(); step(1, 0, E_MEMADR);
    for (int i = 0; i < 3; i++) step(0, 0, E_MEMREAD);
    step(1, 0, E_MEMREAD);
    step(1, 0, E_MEMWB);

    // beq not taken, then taken
    set_ir(7'b1100011, 3'b000); fd(); step(1, 0, E_BR0);
    fd(); step(1, 1, E_BR1);

    // jal, sw, jalr
    set_ir(7'b1101111, 3'b000); fd(); step(1, 0, E_JAL);
    set_ir(7'b0100011, 3'b010); fd(); step(1, 0, E_MEMADR); step(1, 0, E_MEMWR_R);
    set_ir(7'b1100111, 3'b000); fd(); step(1, 0, E_JALR);   step(1, 0, E_JWB);

    // jalr funct3=001: illegal, trap is sticky
    set_ir(7'b1100111, 3'b001); fd();
    chk("illegal_trap", E_TRAP_ILL);
    step(1, 0, E_TRAP_ILL); step(0, 0, E_TRAP_ILL); step(1, 1, E_TRAP_ILL);

    // load with reserved funct3 also traps
    do_reset();
    set_ir(7'b0000011, 3'b011); fd(); step(1, 0, E_TRAP_ILL);

    // fetch timeout: 4 waiting cycles then trap
    do_reset();
    set_ir(7'b0110011, 3'b000);
    for (int i = 0; i < 4; i++) step(0, 0, E_FETCH);
    chk("expired_wait", E_TRAP_TO);
    step(1, 0, E_TRAP_TO); step(1, 0, E_TRAP_TO);

    // ready on exactly the 4th waiting cycle wins
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, E_FETCH);
    step(1, 0, E_FETCH_R);
    step(1, 0, E_DECODE); step(1, 0, E_EXECR); step(1, 0, E_ALUWB);

    // async reset in the middle of a store request
    set_ir(7'b0100011, 3'b000); fd(); step(0, 0, E_MEMADR);
    step(0, 0, E_MEMWR);
    rst_n = 1'b0;
    #1;
    chk("async_reset", E_RST);
    push_wait(E_RST);
    rst_n = 1'b1;
    push_wait(E_RST);
    step(0, 0, E_FETCH);
    step(1, 0, E_FETCH_R);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad != 0) $display("FAIL: %0d mismatches", bad);
    else          $display("PASS");
    $finish;
  end

endmodule

// File: doc/rv_multicycle_control.md
# rv_multicycle_control

Multi-cycle control unit for the RV32I core. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles against a shared, handshaked instruction/data memory. It decodes the full RV32I base opcode set: R, I-ALU, load, store, branch, LUI, AUIPC, JAL and JALR. It traps on illegal encodings and on memory timeouts. It sits between the instruction register and the datapath muxes, register file, ALU and memory port.

## Interface
- MEM_TIMEOUT, default 16: cycles to wait for `mem_ready` before a fault; 0 disables the timeout.
- CNT_W, default 5: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- br_cond  in  1  branch condition evaluated by the ALU for funct3.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write request (valid only with mem_req).
- adr_src  out  1  address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR and oldPC.
- pc_write  out  1  load PC from result.
- reg_write  out  1  register-file write.
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded.
- result_src  out  2  00 ALUOut, 01 mem rdata, 10 ALU result, 11 PC.
- jalr_mask  out  1  clear bit 0 of the PC load value.
- instret  out  1  one-cycle pulse on instruction retire.
- halted  out  1  trap state reached (sticky).
- cause  out  2  00 none, 01 illegal instruction, 10 memory timeout.

## Operation
- All outputs are a Moore decode of the state register. Unlisted outputs are 0 in every state.
- RST: reset state; all outputs 0. Unconditionally moves to FETCH on the next edge.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - On mem_ready: ir_write=1 and pc_write=1 (PC ← PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (ALUOut ← oldPC+imm). Next state by opcode:
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 0000011 → MEMADR, only if funct3 ∈ {000,001,010,100,101}.
  - 0100011 → MEMADR, only if funct3 ∈ {000,001,010}.
  - 1100011 → BRANCH, only if funct3 ∉ {010,011}.
  - 1101111 → JAL.
  - 1100111 → JALR, only if funct3 = 000.
  - 0110111 → LUI.
  - 0010111 → AUIPC.
  - Anything else → TRAP with cause=01.
- EXECR: A=10, B=00, alu_op=10 → ALUWB.
- EXECI: A=10, B=01, alu_op=10 → ALUWB.
- LUI: A=11, B=01, alu_op=00 → ALUWB.
- AUIPC: A=01, B=01, alu_op=00 → ALUWB.
- ALUWB: result_src=00, reg_write=1, instret=1 → FETCH.
- MEMADR: A=10, B=01, alu_op=00. Goes to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, adr_src=1. Goes to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1, instret=1 → FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: instret=1, then FETCH.
- BRANCH: A=10, B=00, alu_op=01, result_src=00, pc_write=br_cond, instret=1 → FETCH.
- JAL: result_src=11, reg_write=1, then pc_write=1 with result_src=00 in the same cycle. The PC load uses ALUOut, the rd write uses PC. Datapath provides separate paths for these. instret=1 → FETCH.
- JALR: A=10, B=01, alu_op=00 → JWB.
- JWB: same as JAL, plus jalr_mask=1.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while mem_ready=0: go to TRAP with cause=10.
  - mem_ready on the same cycle as the limit wins, and the request completes normally.
- TRAP: halted=1, cause held, all strobes 0. Exit only via rst_n.

## Timing
- Reset values:
  - State = RST.
  - All outputs 0, cause=00, wait counter 0.
  - Reset takes effect mid-instruction or mid-request with no completion pulse.
- Latency with zero wait states (mem_ready high on the first request cycle), counting cycles from FETCH entry to return to FETCH:
  - R, I-ALU, LUI, AUIPC, JALR, store: 4 cycles.
  - Load: 5 cycles.
  - Branch, JAL: 3 cycles.
- Each memory wait cycle adds one cycle.
- mem_req stays high and address/we stable until the mem_ready cycle. mem_req drops on the following cycle unless the next state also requests.
- instret fires exactly once per retired instruction. It never fires for a trapped instruction.
- The timeout trap is entered on the edge after the limit cycle.

## Test plan
- Reset, then mem_ready tied 1, IR = add (0110011): RST→FETCH→DECODE→EXECR→ALUWB. reg_write=1 in cycle 4 after FETCH entry, instret=1 in ALUWB.
- lw (0000011, funct3 010) with mem_ready low for 3 cycles in MEMREAD: mem_req/adr_src=1 held 4 cycles. MEMWB follows the ready cycle. Total 8 cycles.
- beq with br_cond=0, then br_cond=1: pc_write=0, then pc_write=1 in BRANCH; both take 3 cycles.
- jalr (1100111, funct3 000): JWB asserts reg_write, pc_write, jalr_mask, result_src=00 for the PC path. A following jalr with funct3=001 → TRAP, cause=01, halted=1, no instret.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: TRAP entered after 4 waiting cycles with cause=10. With mem_ready on exactly the 4th waiting cycle, there is no trap and the FSM goes to DECODE.
- Assert rst_n low during MEMWRITE: outputs go to 0 immediately. RST follows, then FETCH; no store completes.
